hc595_rx: RTL and testbench
===========================

# hc595_rx

Serial-to-parallel receiver for the 74HC595-style three-wire display link (serial data, shift clock, storage latch) driven by our digit-tube output controller. The block oversamples the three lines in the local `clk` domain, shifts data in on each shift-clock rising edge, and transfers the word to a parallel output register on each storage-latch rising edge. It is used for board-to-board loopback of the display bus and as the checking end in system benches.

## Interface
Parameters:
- `WIDTH`, 16: bits per frame, equal to the shift-register chain length.
- `SYNC_STAGES`, 2: synchronizer flops per input line, minimum 2.

Ports:
- `clk`  input  1: sole clock, rising-edge.
- `rst`  input  1: reset, synchronous, active-high.
- `ser_data`  input  1: serial data line, asynchronous to `clk`.
- `ser_shcp`  input  1: shift clock line, asynchronous to `clk`.
- `ser_stcp`  input  1: storage latch line, asynchronous to `clk`.
- `oe_n`  input  1: output enable, active-low, synchronous to `clk`.
- `q`  output  WIDTH: latched word. Reads 0 while `oe_n`=1.
- `q_valid`  output  1: one-cycle pulse when `q` is updated.
- `frame_err`  output  1: one-cycle pulse, coincident with `q_valid`, when the bit count is not WIDTH.
- `err_cnt`  output  8: saturating count of frame errors.

## Operation
- Each line passes through `SYNC_STAGES` flops. `ser_shcp` and `ser_stcp` also get one edge-detect flop.
- Rising shcp edge: `sr <= {data_s, sr[WIDTH-1:1]}`. This is LSB-first, so the first bit received lands in `q[0]` after WIDTH shifts. Also `bit_cnt` increments, saturating at WIDTH+1.
- Rising stcp edge:
  - `q_reg <= sr`.
  - `q_valid` is pulsed.
  - `frame_err` is pulsed if `bit_cnt` != WIDTH, and `err_cnt` increments, saturating at 255.
  - `bit_cnt` returns to 0. `sr` is not cleared.
- Rising shcp and stcp edges detected in the same cycle: the latch takes `sr` before the shift. The shift then happens, and `bit_cnt` becomes 1.
- A latch with zero shifts still updates `q` and pulses `q_valid`. It is a frame error.
- `q = oe_n ? 0 : q_reg`. This gating is combinational and does not affect `q_valid`.
- Warm-up: a counter suppresses edge detection for SYNC_STAGES+1 cycles after reset is released. A line that is already high at reset release is not detected as an edge.

## Timing
- Reset values:
  - `q`=0, `q_reg`=0, `sr`=0, `bit_cnt`=0.
  - `q_valid`=0, `frame_err`=0, `err_cnt`=0.
  - Synchronizers and edge flops = 0.
  - Warm-up counter restarts.
- Latency:
  - A pin edge takes effect SYNC_STAGES+1 `clk` cycles later, i.e. 3 at the default.
  - `q` and `q_valid` change in the same cycle.
- Input constraints:
  - shcp and stcp high time ≥ SYNC_STAGES+1 cycles, and low time ≥ SYNC_STAGES+1 cycles.
  - `ser_data` stable from SYNC_STAGES+1 cycles before an shcp rising edge until SYNC_STAGES+1 cycles after it.
  - Violations are not detected.
- Reset mid-frame discards the partial frame. The first stcp after reset yields a frame error unless WIDTH fresh bits have arrived.

## Configuration
- `HC595_RX_FRAME_CHECK_EN` defined: `bit_cnt`, `frame_err` and `err_cnt` logic is present as described above.
- `HC595_RX_FRAME_CHECK_EN` undefined: no bit counter is built, `frame_err` and `err_cnt` are tied to 0, and `q_valid` still pulses on every latch.

## Structure
- `hc595_pkg` holds:
  - `HC595_WIDTH_DEF` (16) and `HC595_SYNC_DEF` (2).
  - The `err_cnt` width constant (8).
  - The `hc595_word_t` typedef (logic [15:0]).
- Sub-module `hc595_sync_edge`: parameterised synchronizer plus rising-edge detector with warm-up suppression. It is instantiated for shcp and stcp. The data line uses the synchronizer path only.

## Test plan
- 16 bits of 0xA55A, LSB first, at 32-clk shcp period, then stcp pulse → `q`=0xA55A and `q_valid` high 1 cycle, 3 cycles after the stcp rise; `frame_err`=0.
- Same frame with `oe_n`=1 → `q`=0 and `q_valid` still pulses. Drop `oe_n` → `q`=0xA55A the next cycle with no new pulse.
- 15 bits, then stcp → `q` updates, `frame_err`=1, `err_cnt`=1. With the macro undefined → `frame_err`=0 and `err_cnt`=0.
- shcp and stcp rise together after 16 bits of 0xFFFF, with `ser_data`=0 → `q`=0xFFFF, `bit_cnt`=1, and the next latch flags a frame error.
- `rst` asserted after 8 bits, released, then 16 bits of 0x1234 and stcp → `q`=0x1234 with no error. Holding `ser_shcp` high across reset release produces no spurious shift.
- 300 zero-bit latches → `err_cnt` saturates at 255.

Source files
------------

// File: rtl/hc595_pkg.sv
// Shared constants, word type and helpers for the hc595_rx three-wire display-link receiver.
package hc595_pkg;

    localparam int HC595_WIDTH_DEF = 16;
    localparam int HC595_SYNC_DEF  = 2;
    localparam int HC595_ERR_W     = 8;

    typedef logic [HC595_WIDTH_DEF-1:0] hc595_word_t;

    // Saturating increment for the frame-error counter.
    function automatic logic [HC595_ERR_W-1:0] hc595_err_inc(input logic [HC595_ERR_W-1:0] cnt);
        if (cnt == {HC595_ERR_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(HC595_ERR_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/hc595_rx_if.sv
// Bundle of the serial link lines, output enable and parallel result of hc595_rx.
interface hc595_rx_if
    import hc595_pkg::*;
#(
    parameter int WIDTH = HC595_WIDTH_DEF
) ();

    logic                   ser_data;
    logic                   ser_shcp;
    logic                   ser_stcp;
    logic                   oe_n;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic                   frame_err;
    logic [HC595_ERR_W-1:0] err_cnt;

    modport master (
        output ser_data, ser_shcp, ser_stcp, oe_n,
        input  q, q_valid, frame_err, err_cnt
    );

    modport slave (
        input  ser_data, ser_shcp, ser_stcp, oe_n,
        output q, q_valid, frame_err, err_cnt
    );

endinterface

// File: rtl/hc595_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect; edges are masked for SYNC_STAGES+1
// cycles after reset so a line already high at release is not seen as an edge.
module hc595_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic sync_o,
    output logic rise_o
);

    localparam int             WARM   = SYNC_STAGES + 1;
    localparam int             CW     = $clog2(WARM + 1);
    localparam logic [CW-1:0]  WARM_C = CW'(WARM);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [CW-1:0]          warm_q;

    // Synchronizer chain, previous-value flop and warm-up counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            edge_q <= 1'b0;
            warm_q <= {CW{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            edge_q <= sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_C) begin
                warm_q <= warm_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                warm_q <= warm_q;
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q & (warm_q == WARM_C);

endmodule

// File: rtl/hc595_rx.sv
// 74HC595-style serial-to-parallel receiver. Define HC595_RX_FRAME_CHECK_EN to build the
// bit counter and the frame_err / err_cnt logic; otherwise those outputs are tied to 0.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int WIDTH       = HC595_WIDTH_DEF,
    parameter int SYNC_STAGES = HC595_SYNC_DEF
) (
    input  logic      clk,
    input  logic      rst,
    hc595_rx_if.slave bus
);

    logic                   shift_s;
    logic                   latch_s;
    logic                   data_s;
    logic                   shcp_sync_s;
    logic                   stcp_sync_s;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [WIDTH-1:0]       sr_q;
    logic [WIDTH-1:0]       sr_d;
    logic [WIDTH-1:0]       q_reg_q;
    logic [WIDTH-1:0]       q_reg_d;
    logic                   q_valid_q;

    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_shcp (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (bus.ser_shcp),
        .sync_o (shcp_sync_s),
        .rise_o (shift_s)
    );

    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stcp (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (bus.ser_stcp),
        .sync_o (stcp_sync_s),
        .rise_o (latch_s)
    );

    // Data line is only synchronized; it is aligned with the shcp chain so it is
    // sampled at the same depth as the detected clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ser_data};
        end
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Shift register and output latch; a simultaneous latch captures sr before the shift.
    always_comb begin
        sr_d    = sr_q;
        q_reg_d = q_reg_q;
        if (shift_s) begin
            sr_d = {data_s, sr_q[WIDTH-1:1]};
        end else begin
            sr_d = sr_q;
        end
        if (latch_s) begin
            q_reg_d = sr_q;
        end else begin
            q_reg_d = q_reg_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= {WIDTH{1'b0}};
            q_reg_q   <= {WIDTH{1'b0}};
            q_valid_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            q_reg_q   <= q_reg_d;
            q_valid_q <= latch_s;
        end
    end

`ifdef HC595_RX_FRAME_CHECK_EN
    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic [CNT_W-1:0]       bit_cnt_q;
    logic [CNT_W-1:0]       bit_cnt_d;
    logic                   frame_err_q;
    logic                   frame_err_d;
    logic [HC595_ERR_W-1:0] err_cnt_q;
    logic [HC595_ERR_W-1:0] err_cnt_d;

    // Bit counting and frame check; a same-cycle shift counts as the first bit of the next frame.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (latch_s) begin
            frame_err_d = (bit_cnt_q != CNT_FULL);
            if (frame_err_d) begin
                err_cnt_d = hc595_err_inc(err_cnt_q);
            end else begin
                err_cnt_d = err_cnt_q;
            end
            bit_cnt_d = shift_s ? CNT_ONE : CNT_ZERO;
        end else if (shift_s && (bit_cnt_q != CNT_SAT)) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Frame-check registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= CNT_ZERO;
            frame_err_q <= 1'b0;
            err_cnt_q   <= {HC595_ERR_W{1'b0}};
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.frame_err = frame_err_q;
    assign bus.err_cnt   = err_cnt_q;
`else
    assign bus.frame_err = 1'b0;
    assign bus.err_cnt   = {HC595_ERR_W{1'b0}};
`endif

    assign bus.q       = bus.oe_n ? {WIDTH{1'b0}} : q_reg_q;
    assign bus.q_valid = q_valid_q;

endmodule

// File: tb/tb_hc595_rx.sv
// Scoreboard bench for hc595_rx: a bit-level model pushes expected latch results,
// a monitor pops and compares them on every q_valid pulse.
module tb_hc595_rx;
    import hc595_pkg::*;

`ifdef HC595_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    typedef struct {
        hc595_word_t word;
        logic        err;
        logic [7:0]  errs;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hc595_rx_if #(.WIDTH(16)) bus ();

    hc595_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    hc595_word_t m_sr;
    int          m_cnt;
    int          m_errs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every q_valid pulse must match the oldest expected latch.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.q_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("q", 32'(bus.q), bus.oe_n ? 32'd0 : 32'(e.word));
                check_eq("frame_err", 32'(bus.frame_err), 32'(e.err));
                check_eq("err_cnt", 32'(bus.err_cnt), 32'(e.errs));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_shift(input logic b);
        m_sr = {b, m_sr[15:1]};
        if (m_cnt < 17) m_cnt++;
    endtask

    task automatic m_latch();
        exp_t e;
        e.word = m_sr;
        e.err  = FC && (m_cnt != 16);
        if (e.err && m_errs < 255) m_errs++;
        e.errs = 8'(m_errs);
        sb.push_back(e);
        m_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.ser_data = b;
        wait_clk(16);
        bus.ser_shcp = 1'b1;
        m_shift(b);
        wait_clk(16);
        bus.ser_shcp = 1'b0;
    endtask

    task automatic send_word(input hc595_word_t w, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(w[i]);
    endtask

    // Latch pulse with latency/width checks; optionally raises shcp in the same instant.
    task automatic do_latch(input bit with_shift);
        if (with_shift) bus.ser_shcp = 1'b1;
        bus.ser_stcp = 1'b1;
        m_latch();
        if (with_shift) m_shift(bus.ser_data);
        wait_clk(2);
        check_eq("lat_early", 32'(bus.q_valid), 32'd0);
        wait_clk(1);
        check_eq("lat_pulse", 32'(bus.q_valid), 32'd1);
        wait_clk(1);
        check_eq("pulse_width", 32'(bus.q_valid), 32'd0);
        wait_clk(4);
        bus.ser_stcp = 1'b0;
        bus.ser_shcp = 1'b0;
        wait_clk(8);
    endtask

    task automatic model_reset();
        m_sr   = 16'h0000;
        m_cnt  = 0;
        m_errs = 0;
        sb.delete();
    endtask

    initial begin
        bus.ser_data = 1'b0;
        bus.ser_shcp = 1'b0;
        bus.ser_stcp = 1'b0;
        bus.oe_n     = 1'b0;
        rst          = 1'b1;
        model_reset();
        wait_clk(4);
        check_eq("rst_q", 32'(bus.q), 32'd0);
        check_eq("rst_q_valid", 32'(bus.q_valid), 32'd0);
        check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check_eq("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        wait_clk(6);

        // Full frame.
        send_word(16'hA55A, 16);
        do_latch(1'b0);
        check_eq("q_a55a", 32'(bus.q), 32'h0000A55A);

        // Output disabled: q gated, pulse still present; enabling shows the word without a pulse.
        bus.oe_n = 1'b1;
        send_word(16'hA55A, 16);
        do_latch(1'b0);
        check_eq("q_gated", 32'(bus.q), 32'd0);
        bus.oe_n = 1'b0;
        wait_clk(1);
        check_eq("q_oe_on", 32'(bus.q), 32'h0000A55A);
        check_eq("no_pulse_oe", 32'(bus.q_valid), 32'd0);

        // Short frame.
        send_word(16'h3C96, 15);
        do_latch(1'b0);
        check_eq("err_cnt_short", 32'(bus.err_cnt), FC ? 32'd1 : 32'd0);

        // Simultaneous shift and latch.
        send_word(16'hFFFF, 16);
        bus.ser_data = 1'b0;
        wait_clk(8);
        do_latch(1'b1);
        check_eq("q_ffff", 32'(bus.q), 32'h0000FFFF);
        do_latch(1'b0);
        check_eq("q_after_both", 32'(bus.q), 32'h00007FFF);

        // Reset mid-frame with shcp held high across release.
        send_word(16'h00FF, 8);
        rst          = 1'b1;
        bus.ser_data = 1'b1;
        bus.ser_shcp = 1'b1;
        wait_clk(3);
        model_reset();
        check_eq("rst2_q", 32'(bus.q), 32'd0);
        check_eq("rst2_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        wait_clk(6);
        bus.ser_shcp = 1'b0;
        wait_clk(6);
        do_latch(1'b0);
        check_eq("no_spurious_shift", 32'(bus.q), 32'd0);
        send_word(16'h1234, 16);
        do_latch(1'b0);
        check_eq("q_1234", 32'(bus.q), 32'h00001234);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) do_latch(1'b0);
        check_eq("err_sat", 32'(bus.err_cnt), FC ? 32'd255 : 32'd0);

        wait_clk(4);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
